// File: rtl/rsa_pkg.sv
// Shared widths, divider latency and state encoding for the RSA private-key generator.
package rsa_pkg;

    localparam int unsigned W          = 8;
    localparam int unsigned W2         = 2 * W;
    localparam int unsigned WS         = 2 * W + 1;
    localparam int unsigned DIV_CYCLES = W2;
    localparam int unsigned CNT_W      = $clog2(DIV_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        MUL,
        CHECK,
        DIV,
        UPD,
        FIX,
        DONE
    } state_t;

endpackage

// File: rtl/rsa_priv_key_gen_div.sv
// Restoring unsigned W2/W2 divider: go performs the first step, done marks the
// cycle whose clock edge completes the last step; quo/rem are valid from the next cycle.
module rsa_seq_div
    import rsa_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          go,
    input  logic [W2-1:0] dividend,
    input  logic [W2-1:0] divisor,
    output logic [W2-1:0] quo,
    output logic [W2-1:0] rem,
    output logic          done
);

    logic [W2-1:0]    rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             run_q, run_d;
    logic [W2-1:0]    src_r, src_q, src_d, step_r, step_q;
    logic [WS-1:0]    trial;

    always_comb begin
        rem_d  = rem_q;
        quo_d  = quo_q;
        dvs_d  = dvs_q;
        cnt_d  = cnt_q;
        run_d  = run_q;
        src_r  = go ? '0 : rem_q;
        src_q  = go ? dividend : quo_q;
        src_d  = go ? divisor : dvs_q;
        // One restoring step: shift in the next dividend bit, subtract if it fits.
        trial  = {src_r, src_q[W2-1]};
        step_q = {src_q[W2-2:0], 1'b0};
        if (trial >= {1'b0, src_d}) begin
            step_r    = W2'(trial - {1'b0, src_d});
            step_q[0] = 1'b1;
        end else begin
            step_r = W2'(trial);
        end
        if (go) begin
            rem_d = step_r;
            quo_d = step_q;
            dvs_d = divisor;
            cnt_d = CNT_W'(1);
            run_d = 1'b1;
        end else if (run_q) begin
            rem_d = step_r;
            quo_d = step_q;
            if (cnt_q == CNT_W'(DIV_CYCLES - 1)) begin
                run_d = 1'b0;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            dvs_q <= dvs_d;
            cnt_q <= cnt_d;
            run_q <= run_d;
        end
    end

    assign quo  = quo_q;
    assign rem  = rem_q;
    assign done = run_q && (cnt_q == CNT_W'(DIV_CYCLES - 1));

endmodule

// File: rtl/rsa_priv_key_gen.sv
// Computes n = p*q and d = e^-1 mod (p-1)(q-1) with a shift-add multiplier
// followed by extended Euclid driven by a sequential divider.
module rsa_priv_key_gen
    import rsa_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [W-1:0]  p,
    input  logic [W-1:0]  q,
    input  logic [W-1:0]  e,
    output logic [W2-1:0] n,
    output logic [W2-1:0] d,
    output logic          error,
    output logic          busy,
    output logic          finish
);

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [W2-1:0]         a_n_q, a_n_d, a_f_q, a_f_d, acc_n_q, acc_n_d, acc_f_q, acc_f_d;
    logic [W-1:0]          b_n_q, b_n_d, b_f_q, b_f_d, e_q, e_d;
    logic                  inval_q, inval_d;
    logic [W2-1:0]         r0_q, r0_d, r1_q, r1_d;
    logic signed [WS-1:0]  t0_q, t0_d, t1_q, t1_d;
    logic [W2-1:0]         n_q, n_d, d_q, d_d;
    logic                  error_q, error_d, busy_q, busy_d, finish_q, finish_d;
    logic                  div_go_q, div_go_d;
    logic [W2-1:0]         div_quo, div_rem;
    logic                  div_done;
    logic signed [WS-1:0]  quo_s, phi_s;

    assign quo_s = $signed({1'b0, div_quo});
    assign phi_s = $signed({1'b0, acc_f_q});

    rsa_seq_div u_div (
        .clk      (clk),
        .rst      (rst),
        .go       (div_go_q),
        .dividend (r0_q),
        .divisor  (r1_q),
        .quo      (div_quo),
        .rem      (div_rem),
        .done     (div_done)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_n_d   = a_n_q;
        a_f_d   = a_f_q;
        b_n_d   = b_n_q;
        b_f_d   = b_f_q;
        acc_n_d = acc_n_q;
        acc_f_d = acc_f_q;
        e_d     = e_q;
        inval_d = inval_q;
        r0_d    = r0_q;
        r1_d    = r1_q;
        t0_d    = t0_q;
        t1_d    = t1_q;
        n_d     = n_q;
        d_d     = d_q;
        error_d = error_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_n_d   = W2'(p);
                    b_n_d   = q;
                    a_f_d   = W2'(p - W'(1));
                    b_f_d   = q - W'(1);
                    acc_n_d = '0;
                    acc_f_d = '0;
                    e_d     = e;
                    inval_d = (p < W'(2)) || (q < W'(2)) || (e == '0);
                    cnt_d   = '0;
                    state_d = MUL;
                end
            end
            MUL: begin
                // p*q and (p-1)*(q-1) share the same shift schedule.
                if (b_n_q[0]) acc_n_d = acc_n_q + a_n_q;
                if (b_f_q[0]) acc_f_d = acc_f_q + a_f_q;
                a_n_d = a_n_q << 1;
                a_f_d = a_f_q << 1;
                b_n_d = b_n_q >> 1;
                b_f_d = b_f_q >> 1;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(W - 1)) state_d = CHECK;
            end
            CHECK: begin
                if (inval_q || (acc_f_q == W2'(1))) begin
                    n_d     = acc_n_q;
                    d_d     = '0;
                    error_d = inval_q;
                    state_d = DONE;
                end else begin
                    r0_d    = acc_f_q;
                    r1_d    = W2'(e_q);
                    t0_d    = '0;
                    t1_d    = WS'(1);
                    state_d = DIV;
                end
            end
            DIV: begin
                if (div_done) state_d = UPD;
            end
            UPD: begin
                r0_d    = r1_q;
                r1_d    = div_rem;
                t0_d    = t1_q;
                t1_d    = t0_q - quo_s * t1_q;
                state_d = (div_rem == '0) ? FIX : DIV;
            end
            FIX: begin
                n_d = acc_n_q;
                if (r0_q != W2'(1)) begin
                    d_d     = '0;
                    error_d = 1'b1;
                end else begin
                    d_d     = t0_q[WS-1] ? W2'(t0_q + phi_s) : W2'(t0_q);
                    error_d = 1'b0;
                end
                state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d   = (state_d != IDLE) && (state_d != DONE);
        finish_d = (state_d == DONE);
        div_go_d = (state_d == DIV) && (state_q != DIV);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_n_q    <= '0;
            a_f_q    <= '0;
            b_n_q    <= '0;
            b_f_q    <= '0;
            acc_n_q  <= '0;
            acc_f_q  <= '0;
            e_q      <= '0;
            inval_q  <= 1'b0;
            r0_q     <= '0;
            r1_q     <= '0;
            t0_q     <= '0;
            t1_q     <= '0;
            n_q      <= '0;
            d_q      <= '0;
            error_q  <= 1'b0;
            busy_q   <= 1'b0;
            finish_q <= 1'b0;
            div_go_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_n_q    <= a_n_d;
            a_f_q    <= a_f_d;
            b_n_q    <= b_n_d;
            b_f_q    <= b_f_d;
            acc_n_q  <= acc_n_d;
            acc_f_q  <= acc_f_d;
            e_q      <= e_d;
            inval_q  <= inval_d;
            r0_q     <= r0_d;
            r1_q     <= r1_d;
            t0_q     <= t0_d;
            t1_q     <= t1_d;
            n_q      <= n_d;
            d_q      <= d_d;
            error_q  <= error_d;
            busy_q   <= busy_d;
            finish_q <= finish_d;
            div_go_q <= div_go_d;
        end
    end

    assign n      = n_q;
    assign d      = d_q;
    assign error  = error_q;
    assign busy   = busy_q;
    assign finish = finish_q;

endmodule

// File: tb/tb_rsa_priv_key_gen.sv
// Bench for rsa_priv_key_gen: directed table, handshake corner cases and random
// vectors against a brute-force modular-inverse reference model.
module tb_rsa_priv_key_gen;
    import rsa_pkg::*;

    localparam int WI    = int'(W);
    localparam int LIMIT = WI + 3 + 3 * WI * (2 * WI + 1) + 20;

    logic          clk = 1'b0;
    logic          rst, start;
    logic [W-1:0]  p, q, e;
    logic [W2-1:0] n, d;
    logic          error, busy, finish;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int p; int q; int e;
        int n; int d; bit err;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    rsa_priv_key_gen dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .p      (p),
        .q      (q),
        .e      (e),
        .n      (n),
        .d      (d),
        .error  (error),
        .busy   (busy),
        .finish (finish)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Inverse found by exhaustive search; Euclid is used only to count iterations.
    function automatic void ref_model(input int pp, input int qq, input int ee,
                                      output int rn, output int rd, output bit rerr,
                                      output int rlat);
        longint phi, a, b, r;
        int k;
        rn   = pp * qq;
        phi  = longint'(pp - 1) * longint'(qq - 1);
        rd   = 0;
        rerr = 1'b1;
        rlat = WI + 2;
        if (pp < 2 || qq < 2 || ee == 0) return;
        if (phi == 1) begin
            rerr = 1'b0;
            return;
        end
        k = 0;
        a = phi;
        b = ee;
        while (b != 0) begin
            r = a % b;
            a = b;
            b = r;
            k++;
        end
        rlat = WI + 3 + k * (2 * WI + 1);
        for (longint x = 1; x < phi; x++) begin
            if ((x * ee) % phi == 1) begin
                rd   = int'(x);
                rerr = 1'b0;
                break;
            end
        end
    endfunction

    task automatic run(input int pp, input int qq, input int ee, input bit inject,
                       output int on, output int od, output bit oerr, output int lat);
        logic [W2-1:0] hn, hd;
        logic he;
        bit held, seen;
        held = 1'b1;
        seen = 1'b0;
        @(negedge clk);
        hn = n; hd = d; he = error;
        start = 1'b1;
        p = W'(pp); q = W'(qq); e = W'(ee);
        @(posedge clk);
        lat = 1;
        #1;
        chk("busy_after_start", busy, 1);
        if (n != hn || d != hd || error != he) held = 1'b0;
        start = 1'b0;
        p = W'($urandom); q = W'($urandom); e = W'($urandom);
        while (lat < LIMIT) begin
            @(posedge clk);
            lat++;
            #1;
            if (finish) begin
                seen = 1'b1;
                break;
            end
            if (n != hn || d != hd || error != he) held = 1'b0;
            if (inject && lat == 4) begin
                start = 1'b1;
                p = W'(7); q = W'(11); e = W'(3);
            end else begin
                start = 1'b0;
            end
        end
        chk("finish_seen", seen, 1);
        chk("outputs_held_until_finish", held, 1);
        chk("busy_low_at_finish", busy, 0);
        on = int'(n); od = int'(d); oerr = error;
        @(posedge clk);
        #1;
        chk("finish_single_pulse", finish, 0);
    endtask

    initial begin
        int rn, rd, rl, gn, gd, gl;
        bit rerr, gerr, quiet;

        vecs.push_back('{61, 53, 17, 3233, 2753, 1'b0});
        vecs.push_back('{34, 12, 5, 408, 218, 1'b0});
        vecs.push_back('{34, 12, 3, 408, 0, 1'b1});
        vecs.push_back('{251, 241, 7, 60491, 17143, 1'b0});
        vecs.push_back('{3, 5, 1, 15, 1, 1'b0});
        vecs.push_back('{1, 7, 5, 7, 0, 1'b1});
        vecs.push_back('{2, 2, 3, 4, 0, 1'b0});
        vecs.push_back('{0, 5, 3, 0, 0, 1'b1});
        vecs.push_back('{11, 13, 0, 143, 0, 1'b1});
        vecs.push_back('{3, 5, 13, 15, 5, 1'b0});

        rst = 1'b1; start = 1'b0; p = '0; q = '0; e = '0;
        repeat (2) @(negedge clk);
        chk("reset_n", n, 0);
        chk("reset_d", d, 0);
        chk("reset_error", error, 0);
        chk("reset_busy", busy, 0);
        chk("reset_finish", finish, 0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            ref_model(vecs[i].p, vecs[i].q, vecs[i].e, rn, rd, rerr, rl);
            run(vecs[i].p, vecs[i].q, vecs[i].e, 1'b0, gn, gd, gerr, gl);
            chk($sformatf("vec%0d_n", i), gn, vecs[i].n);
            chk($sformatf("vec%0d_d", i), gd, vecs[i].d);
            chk($sformatf("vec%0d_error", i), gerr, vecs[i].err);
            chk($sformatf("vec%0d_latency", i), gl, rl);
        end

        // Second start while busy must be ignored.
        run(61, 53, 17, 1'b1, gn, gd, gerr, gl);
        chk("busy_start_n", gn, 3233);
        chk("busy_start_d", gd, 2753);
        chk("busy_start_error", gerr, 0);
        @(negedge clk);
        chk("busy_start_no_extra_run", busy, 0);

        // Reset in the middle of DIV aborts immediately.
        @(negedge clk);
        start = 1'b1; p = W'(251); q = W'(241); e = W'(7);
        @(negedge clk);
        start = 1'b0;
        repeat (WI + 4) @(negedge clk);
        chk("pre_abort_busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        chk("abort_n", n, 0);
        chk("abort_d", d, 0);
        chk("abort_error", error, 0);
        chk("abort_busy", busy, 0);
        chk("abort_finish", finish, 0);
        quiet = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2 * LIMIT / 10) begin
            @(posedge clk);
            #1;
            if (finish || busy) quiet = 1'b0;
        end
        chk("abort_no_finish", quiet, 1);

        // Back-to-back: scenario 3 must not disturb scenario 1 outputs until its finish.
        run(61, 53, 17, 1'b0, gn, gd, gerr, gl);
        chk("b2b_first_d", gd, 2753);
        ref_model(251, 241, 7, rn, rd, rerr, rl);
        run(251, 241, 7, 1'b0, gn, gd, gerr, gl);
        chk("b2b_second_n", gn, 60491);
        chk("b2b_second_d", gd, 17143);
        chk("b2b_second_latency", gl, rl);

        for (int i = 0; i < 25; i++) begin
            int rp, rq, re;
            rp = int'($urandom_range(0, 255));
            rq = int'($urandom_range(0, 255));
            re = int'($urandom_range(0, 255));
            ref_model(rp, rq, re, rn, rd, rerr, rl);
            run(rp, rq, re, 1'b0, gn, gd, gerr, gl);
            chk($sformatf("rnd%0d_n(%0d,%0d,%0d)", i, rp, rq, re), gn, rn);
            chk($sformatf("rnd%0d_d(%0d,%0d,%0d)", i, rp, rq, re), gd, rd);
            chk($sformatf("rnd%0d_error(%0d,%0d,%0d)", i, rp, rq, re), gerr, rerr);
            chk($sformatf("rnd%0d_latency(%0d,%0d,%0d)", i, rp, rq, re), gl, rl);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
